// File: rtl/dms_pkg.sv
// rtl/dms_pkg.sv - shared parameters, Regsrc codes, IR fields and frame type for dms_core
package dms_pkg;

  localparam int WIDTH = 16;
  localparam int NREG  = 16;
  localparam int DEPTH = 8;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int F1_HI = 7;
  localparam int F1_LO = 4;
  localparam int F2_HI = 3;
  localparam int F2_LO = 0;

  typedef enum logic [1:0] {
    SRC_IMR = 2'd0,
    SRC_IO  = 2'd1,
    SRC_W21 = 2'd2,
    SRC_W22 = 2'd3
  } regsrc_t;

  // regs[14] is r15 and regs[0] is r1, matching the fcOut bit layout
  typedef struct packed {
    logic [NREG-2:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]           ra;
  } frame_t;

endpackage

// File: rtl/dms_frame_stack.sv
// rtl/dms_frame_stack.sv - DEPTH-entry LIFO of register frames
module dms_frame_stack
  import dms_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  frame_t push_frame,
  output frame_t top_frame,
  output logic   full,
  output logic   empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  frame_t         mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] top_idx;

  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp - SPW'(1);
  assign top_frame = mem[top_idx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !pop && !full) begin
      mem[sp[AW-1:0]] <= push_frame;
      sp <= sp + SPW'(1);
    end else if (pop && !push && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

endmodule

// File: rtl/dms_core.sv
// rtl/dms_core.sv - register file, RA, io register, compare and frame backup/restore
module dms_core
  import dms_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        backup,
  input  logic                        restore,
  input  logic                        cmpeq,
  input  logic                        cmpne,
  input  logic                        RegW1,
  input  logic                        RegW2,
  input  logic                        RegR1,
  input  logic                        RegR2,
  input  logic                        writeCR,
  input  logic                        w1,
  input  logic [1:0]                  Regsrc,
  input  logic [WIDTH-1:0]            ioIn,
  input  logic [WIDTH-1:0]            RAIn,
  input  logic [WIDTH-1:0]            IR,
  input  logic [WIDTH-1:0]            ImR,
  input  logic [WIDTH-1:0]            w2_1,
  input  logic [WIDTH-1:0]            w2_2,
  output logic [3:0]                  op,
  output logic [WIDTH-1:0]            RAOut,
  output logic [WIDTH-1:0]            ImROut,
  output logic [WIDTH-1:0]            ioOut,
  output logic [WIDTH-1:0]            A,
  output logic [WIDTH-1:0]            B,
  output logic                        cmp_result,
  output logic [(NREG-1)*WIDTH-1:0]   fcOut
);

  logic [NREG-1:1][WIDTH-1:0] regs_q;
  logic [NREG-1:0][WIDTH-1:0] rf_view;
  logic [WIDTH-1:0]           ra_q;
  logic [WIDTH-1:0]           io_q;
  logic [3:0]                 f1, f2;
  logic [WIDTH-1:0]           wd1, wd2;
  logic                       stk_full, stk_empty, do_push, do_pop;
  frame_t                     push_frame, top_frame;
  logic                       unused_ir;

  assign op        = IR[OP_HI:OP_LO];
  assign f1        = IR[F1_HI:F1_LO];
  assign f2        = IR[F2_HI:F2_LO];
  assign unused_ir = ^IR[11:8];
  assign ImROut    = ImR;
  assign RAOut     = ra_q;
  assign ioOut     = io_q;
  assign fcOut     = regs_q;

  // r0 is materialised as a constant zero slot so reads need no special case
  assign rf_view = {regs_q, {WIDTH{1'b0}}};
  assign A = RegR1 ? rf_view[f1] : '0;
  assign B = RegR2 ? rf_view[f2] : '0;
  assign cmp_result = (cmpeq && (A == B)) || (cmpne && (A != B));

  assign wd1 = w1 ? w2_2 : w2_1;
  always_comb begin
    wd2 = ImR;
    unique case (Regsrc)
      SRC_IMR: wd2 = ImR;
      SRC_IO:  wd2 = ioIn;
      SRC_W21: wd2 = w2_1;
      SRC_W22: wd2 = w2_2;
      default: wd2 = ImR;
    endcase
  end

  assign do_push = backup && !restore && !stk_full;
  assign do_pop  = restore && !backup && !stk_empty;

  // Snapshot uses pre-edge registers, so same-cycle writes land after the push
  assign push_frame.regs = regs_q;
  assign push_frame.ra   = RAIn;

  dms_frame_stack u_stack (
    .clk        (clk),
    .reset      (reset),
    .push       (do_push),
    .pop        (do_pop),
    .push_frame (push_frame),
    .top_frame  (top_frame),
    .full       (stk_full),
    .empty      (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      ra_q   <= '0;
      io_q   <= '0;
    end else begin
      if (writeCR) io_q <= A;
      if (do_pop) begin
        regs_q <= top_frame.regs;
        ra_q   <= top_frame.ra;
      end else begin
        ra_q <= RAIn;
        // port 2 is evaluated last so it wins an address collision
        for (int i = 1; i < NREG; i++) begin
          if (RegW1 && f1 == 4'(i)) regs_q[i] <= wd1;
          if (RegW2 && f2 == 4'(i)) regs_q[i] <= wd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_dms_core.sv
// tb/tb_dms_core.sv - directed self-checking bench for dms_core
module tb_dms_core;
  import dms_pkg::*;

  logic clk = 1'b0;
  logic reset, backup, restore, cmpeq, cmpne, RegW1, RegW2, RegR1, RegR2, writeCR, w1;
  logic [1:0] Regsrc;
  logic [15:0] ioIn, RAIn, IR, ImR, w2_1, w2_2;
  logic [3:0] op;
  logic [15:0] RAOut, ImROut, ioOut, A, B;
  logic cmp_result;
  logic [239:0] fcOut;
  logic [239:0] exp_fc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dms_core dut (
    .clk(clk), .reset(reset), .backup(backup), .restore(restore),
    .cmpeq(cmpeq), .cmpne(cmpne), .RegW1(RegW1), .RegW2(RegW2),
    .RegR1(RegR1), .RegR2(RegR2), .writeCR(writeCR), .w1(w1),
    .Regsrc(Regsrc), .ioIn(ioIn), .RAIn(RAIn), .IR(IR), .ImR(ImR),
    .w2_1(w2_1), .w2_2(w2_2), .op(op), .RAOut(RAOut), .ImROut(ImROut),
    .ioOut(ioOut), .A(A), .B(B), .cmp_result(cmp_result), .fcOut(fcOut)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [239:0] obs, input logic [239:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr2(input logic [3:0] addr, input logic [15:0] val);
    IR = {12'h000, addr};
    Regsrc = 2'd0;
    ImR = val;
    RegW2 = 1'b1;
    tick();
    RegW2 = 1'b0;
  endtask

  task automatic fill(input int base);
    for (int k = 1; k <= 14; k++) wr2(4'(k), 16'(base + k - 1));
  endtask

  function automatic logic [239:0] frame_of(input int base);
    logic [239:0] v;
    v = '0;
    for (int k = 1; k <= 14; k++) v[(k-1)*16 +: 16] = 16'(base + k - 1);
    return v;
  endfunction

  task automatic do_backup(input logic [15:0] ra);
    RAIn = ra;
    backup = 1'b1;
    tick();
    backup = 1'b0;
    RAIn = 16'h0;
  endtask

  task automatic do_restore();
    restore = 1'b1;
    tick();
    restore = 1'b0;
  endtask

  initial begin
    reset = 1'b1; backup = 0; restore = 0; cmpeq = 0; cmpne = 0;
    RegW1 = 0; RegW2 = 0; RegR1 = 0; RegR2 = 0; writeCR = 0; w1 = 0;
    Regsrc = 0; ioIn = 0; RAIn = 0; IR = 0; ImR = 0; w2_1 = 0; w2_2 = 0;
    tick();
    reset = 1'b0;
    RegR1 = 1; RegR2 = 1; IR = 16'h0012;
    #1;
    chk("reset_A", 240'(A), 240'(0));
    chk("reset_B", 240'(B), 240'(0));
    chk("reset_ra", 240'(RAOut), 240'(0));
    chk("reset_io", 240'(ioOut), 240'(0));
    chk("reset_fc", fcOut, 240'(0));
    IR = 16'hA312;
    #1;
    chk("op_field", 240'(op), 240'(4'hA));

    fill(1);
    for (int k = 1; k <= 14; k++) begin
      IR = 16'(k);
      #1;
      chk($sformatf("rd_B_r%0d", k), 240'(B), 240'(k));
    end
    chk("fc_r1", 240'(fcOut[15:0]), 240'(1));
    chk("fc_r15", 240'(fcOut[239:224]), 240'(0));

    do_backup(16'd50);
    fill(15);
    do_backup(16'd51);
    fill(29);
    do_backup(16'd52);
    do_restore();
    chk("lifo1_fc", fcOut, frame_of(29));
    chk("lifo1_ra", 240'(RAOut), 240'(52));
    do_restore();
    chk("lifo2_fc", fcOut, frame_of(15));
    chk("lifo2_ra", 240'(RAOut), 240'(51));
    do_restore();
    chk("lifo3_fc", fcOut, frame_of(1));
    chk("lifo3_ra", 240'(RAOut), 240'(50));

    RAIn = 16'd7;
    do_restore();
    chk("empty_restore_fc", fcOut, frame_of(1));
    chk("empty_restore_ra", 240'(RAOut), 240'(7));

    for (int i = 0; i <= DEPTH; i++) begin
      wr2(4'd1, 16'(100 + i));
      do_backup(16'(200 + i));
    end
    for (int j = 0; j < DEPTH; j++) begin
      do_restore();
      chk($sformatf("deep_r1_%0d", j), 240'(fcOut[15:0]), 240'(100 + DEPTH - 1 - j));
      chk($sformatf("deep_ra_%0d", j), 240'(RAOut), 240'(200 + DEPTH - 1 - j));
    end
    RAIn = 16'd3;
    do_restore();
    chk("deep_empty_r1", 240'(fcOut[15:0]), 240'(100));
    chk("deep_empty_ra", 240'(RAOut), 240'(3));

    wr2(4'd1, 16'h0055);
    do_backup(16'h0099);
    wr2(4'd1, 16'h0066);
    RAIn = 16'h0011; backup = 1; restore = 1;
    tick();
    backup = 0; restore = 0;
    chk("both_r1", 240'(fcOut[15:0]), 240'(16'h0066));
    chk("both_ra", 240'(RAOut), 240'(16'h0011));
    do_restore();
    chk("after_both_r1", 240'(fcOut[15:0]), 240'(16'h0055));
    chk("after_both_ra", 240'(RAOut), 240'(16'h0099));

    wr2(4'd1, 16'd5);
    wr2(4'd2, 16'd5);
    IR = 16'h0012; cmpeq = 1;
    #1;
    chk("cmpeq_equal", 240'(cmp_result), 240'(1));
    cmpeq = 0; cmpne = 1;
    #1;
    chk("cmpne_equal", 240'(cmp_result), 240'(0));
    cmpne = 0;
    #1;
    chk("cmp_none", 240'(cmp_result), 240'(0));
    writeCR = 1;
    tick();
    writeCR = 0;
    chk("io_load", 240'(ioOut), 240'(5));
    wr2(4'd2, 16'd6);
    IR = 16'h0012; cmpne = 1;
    #1;
    chk("cmpne_diff", 240'(cmp_result), 240'(1));
    cmpne = 0; cmpeq = 1;
    #1;
    chk("cmpeq_diff", 240'(cmp_result), 240'(0));
    cmpeq = 0;
    tick();
    chk("io_hold", 240'(ioOut), 240'(5));

    IR = 16'h0033; RegW1 = 1; w1 = 0; w2_1 = 16'hAAAA;
    RegW2 = 1; Regsrc = 2'd3; w2_2 = 16'hBBBB;
    tick();
    RegW1 = 0; RegW2 = 0;
    chk("conflict_r3", 240'(fcOut[47:32]), 240'(16'hBBBB));
    IR = 16'h0040; RegW1 = 1; w1 = 1; w2_2 = 16'h1234;
    tick();
    RegW1 = 0;
    chk("port1_w22_r4", 240'(fcOut[63:48]), 240'(16'h1234));
    IR = 16'h0005; RegW2 = 1; Regsrc = 2'd1; ioIn = 16'h7777;
    tick();
    RegW2 = 0;
    chk("port2_io_r5", 240'(fcOut[79:64]), 240'(16'h7777));
    IR = 16'h0006; RegW2 = 1; Regsrc = 2'd2; w2_1 = 16'h4321;
    tick();
    RegW2 = 0;
    chk("port2_w21_r6", 240'(fcOut[95:80]), 240'(16'h4321));

    exp_fc = fcOut;
    IR = 16'h0000; RegW2 = 1; Regsrc = 2'd0; ImR = 16'hFFFF;
    RegW1 = 1; w1 = 0; w2_1 = 16'hFFFF;
    tick();
    RegW1 = 0; RegW2 = 0;
    chk("r0_A", 240'(A), 240'(0));
    chk("r0_B", 240'(B), 240'(0));
    chk("r0_fc_unchanged", fcOut, exp_fc);

    IR = 16'h0001; RegW2 = 1; Regsrc = 2'd0; ImR = 16'd9;
    RAIn = 16'h0020; backup = 1;
    tick();
    backup = 0; RegW2 = 0;
    chk("backup_write_r1", 240'(fcOut[15:0]), 240'(9));
    IR = 16'h0021; RegW1 = 1; w1 = 0; w2_1 = 16'h00DD;
    RegW2 = 1; ImR = 16'h00EE; restore = 1;
    tick();
    RegW1 = 0; RegW2 = 0; restore = 0;
    chk("restore_wins_r1", 240'(fcOut[15:0]), 240'(5));
    chk("restore_wins_r2", 240'(fcOut[31:16]), 240'(6));
    chk("restore_wins_ra", 240'(RAOut), 240'(16'h0020));

    fill(1);
    do_backup(16'd77);
    reset = 1;
    tick();
    reset = 0;
    chk("midreset_fc", fcOut, 240'(0));
    RAIn = 16'd4;
    do_restore();
    chk("midreset_empty_fc", fcOut, 240'(0));
    chk("midreset_empty_ra", 240'(RAOut), 240'(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
